// File: rtl/avg_seq_ctrl.sv
// rtl/avg_seq_ctrl.sv - sequenced averager: one adder accumulates a frame, one shifter scales it
// Samples stream in over valid/ready; the scaled, truncated sum leaves over valid/ready.
module avg_seq_ctrl #(
  parameter int N_SAMPLES = 8,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int N_SHIFT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [7:0]        sa,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic              busy,
  output logic [7:0]        sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SHIFT, S_DONE} state_t;

  localparam logic [7:0] LAST_SAMPLE = 8'(N_SAMPLES - 1);
  localparam logic [7:0] LAST_SHIFT  = (N_SHIFT > 0) ? 8'(N_SHIFT - 1) : 8'd0;
  localparam state_t     AFTER_ACC   = (N_SHIFT > 0) ? S_SHIFT : S_DONE;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [7:0]               r_sa_lat;
  logic [7:0]               r_sample_cnt;
  logic [7:0]               r_shift_cnt;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_avg;

  logic                     w_in_ready;
  logic                     w_accept;
  logic signed [ACC_W-1:0]  w_sext;
  logic [4:0]               w_amt;

  assign w_in_ready = !rst && (r_state == S_IDLE || r_state == S_ACC);
  assign w_accept   = in_valid && w_in_ready;
  assign w_sext     = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
  // A negative latched shift amount means "no shift".
  assign w_amt      = r_sa_lat[7] ? 5'd0 : r_sa_lat[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_sa_lat     <= '0;
      r_sample_cnt <= '0;
      r_shift_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_out_avg    <= '0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_sample_cnt <= '0;
      r_shift_cnt  <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc        <= w_sext;
            r_sa_lat     <= sa;
            r_sample_cnt <= 8'd1;
            r_shift_cnt  <= '0;
            r_state      <= (N_SAMPLES == 1) ? AFTER_ACC : S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc        <= r_acc + w_sext;
            r_sample_cnt <= r_sample_cnt + 8'd1;
            if (r_sample_cnt == LAST_SAMPLE) begin
              r_shift_cnt <= '0;
              r_state     <= AFTER_ACC;
            end
          end
        end
        S_SHIFT: begin
          r_acc       <= r_acc >>> w_amt;
          r_shift_cnt <= r_shift_cnt + 8'd1;
          if (r_shift_cnt == LAST_SHIFT) r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle loads the result; later cycles wait for the handshake.
          if (!r_out_valid) begin
            r_out_avg   <= r_acc[DATA_W-1:0];
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_sample_cnt <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_avg    = r_out_avg;
  assign busy       = (r_state != S_IDLE);
  assign sample_cnt = r_sample_cnt;

endmodule
